// File: rtl/mem_arbiter.sv
// mem_arbiter
// Sequences the single shared memory port between the instruction fetcher
// (port F) and the load/store accessor (port A). One transaction is in
// flight at a time. A has priority because it holds the older instruction,
// and a starvation counter forces an F grant after STARVE_LIMIT consecutive
// A grants while F was waiting.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   fetch_req/fetch_addr        F read request (held until fetch_done)
//   fetch_done/fetch_rdata      F completion pulse and registered read data
//   access_req/addr/wdata/wstrb A request (wstrb == 0 means read)
//   access_done/access_rdata    A completion pulse and registered read data
//   mem_ready/addr/wdata/wstrb  memory request, held until mem_valid
//   mem_valid/mem_rdata         memory acknowledge and read data
//   mem_err                     sticky timeout flag
//
// Optional feature macro: MEM_TIMEOUT_EN enables a watchdog that abandons a
// silent memory transaction after TIMEOUT_CYCLES busy cycles, returning
// 32'hFFFF_FFFF to the requester and setting mem_err. Without it mem_err is 0.

module mem_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_done,
  output logic [31:0] fetch_rdata,
  input  logic        access_req,
  input  logic [31:0] access_addr,
  input  logic [31:0] access_wdata,
  input  logic [3:0]  access_wstrb,
  output logic        access_done,
  output logic [31:0] access_rdata,
  output logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_A = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // Elaboration-time guard on the parameter ranges.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t      state, state_n;
  logic [3:0]  starve_cnt, starve_cnt_n;
  logic        mem_ready_n;
  logic [31:0] mem_addr_n, mem_wdata_n;
  logic [3:0]  mem_wstrb_n;
  logic        fetch_done_n, access_done_n;
  logic [31:0] fetch_rdata_n, access_rdata_n;

  logic        turnaround, fetch_go, access_go;
  logic        timeout, resp;
  logic [31:0] resp_data;

  // The cycle in which a done pulse is visible is a turnaround cycle: the
  // finishing requester is dropping its request, and no new grant is made,
  // which gives the 3-cycle minimum per transaction.
  assign turnaround = fetch_done | access_done;
  assign fetch_go   = fetch_req  & ~turnaround;
  assign access_go  = access_req & ~turnaround;

  // A transaction ends either on the memory acknowledge or on a watchdog
  // expiry; the latter returns all-ones data.
  assign resp      = (state != IDLE) && (mem_valid || timeout);
  assign resp_data = mem_valid ? mem_rdata : 32'hFFFF_FFFF;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wdog;
  logic       err;

  assign timeout = (state != IDLE) && !mem_valid && (wdog == WDOG_LAST);
  assign mem_err = err;

  // Watchdog counts busy cycles and is zero whenever a new grant lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog <= '0;
      err  <= 1'b0;
    end else begin
      if (state == IDLE || resp) begin
        wdog <= '0;
      end else begin
        wdog <= wdog + 8'd1;
      end
      if (timeout) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      mem_ready    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      fetch_done   <= 1'b0;
      access_done  <= 1'b0;
      fetch_rdata  <= '0;
      access_rdata <= '0;
    end else begin
      state        <= state_n;
      starve_cnt   <= starve_cnt_n;
      mem_ready    <= mem_ready_n;
      mem_addr     <= mem_addr_n;
      mem_wdata    <= mem_wdata_n;
      mem_wstrb    <= mem_wstrb_n;
      fetch_done   <= fetch_done_n;
      access_done  <= access_done_n;
      fetch_rdata  <= fetch_rdata_n;
      access_rdata <= access_rdata_n;
    end
  end

  // Arbitration and transaction sequencing.
  always_comb begin
    state_n        = state;
    starve_cnt_n   = starve_cnt;
    mem_ready_n    = mem_ready;
    mem_addr_n     = mem_addr;
    mem_wdata_n    = mem_wdata;
    mem_wstrb_n    = mem_wstrb;
    fetch_done_n   = 1'b0;
    access_done_n  = 1'b0;
    fetch_rdata_n  = fetch_rdata;
    access_rdata_n = access_rdata;

    case (state)
      IDLE: begin
        if (access_go && (!fetch_go || starve_cnt < STARVE_MAX)) begin
          state_n     = BUSY_A;
          mem_ready_n = 1'b1;
          mem_addr_n  = access_addr;
          mem_wdata_n = access_wdata;
          mem_wstrb_n = access_wstrb;
          // Only grants that pass over a waiting F count toward starvation.
          if (fetch_go) begin
            starve_cnt_n = starve_cnt + 4'd1;
          end
        end else if (fetch_go) begin
          state_n      = BUSY_F;
          starve_cnt_n = '0;
          mem_ready_n  = 1'b1;
          mem_addr_n   = fetch_addr;
          mem_wdata_n  = '0;
          mem_wstrb_n  = '0;
        end
      end
      BUSY_F: begin
        if (resp) begin
          state_n       = IDLE;
          mem_ready_n   = 1'b0;
          fetch_done_n  = 1'b1;
          fetch_rdata_n = resp_data;
        end
      end
      BUSY_A: begin
        if (resp) begin
          state_n        = IDLE;
          mem_ready_n    = 1'b0;
          access_done_n  = 1'b1;
          access_rdata_n = resp_data;
        end
      end
      default: begin
        state_n     = IDLE;
        mem_ready_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Scoreboard bench for mem_arbiter. Expected completions are queued when a
// request is driven and popped when a done pulse appears. A behavioural
// memory answers mem_ready after mem_lat cycles with data mem_addr ^ 32'h53.

module tb_mem_arbiter;

  localparam int STARVE_LIMIT   = 4;
  localparam int TIMEOUT_CYCLES = 8;

  typedef struct packed {
    logic        is_fetch;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_done;
  logic [31:0] fetch_rdata;
  logic        access_req;
  logic [31:0] access_addr;
  logic [31:0] access_wdata;
  logic [3:0]  access_wstrb;
  logic        access_done;
  logic [31:0] access_rdata;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  int          mem_lat      = 0;
  logic        mem_silent   = 1'b0;
  logic        inject_valid = 1'b0;
  logic [31:0] inject_data  = '0;
  int          overlap_cnt  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .STARVE_LIMIT  (STARVE_LIMIT),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_done  (fetch_done),
    .fetch_rdata (fetch_rdata),
    .access_req  (access_req),
    .access_addr (access_addr),
    .access_wdata(access_wdata),
    .access_wstrb(access_wstrb),
    .access_done (access_done),
    .access_rdata(access_rdata),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_valid   (mem_valid),
    .mem_rdata   (mem_rdata),
    .mem_err     (mem_err)
  );

  // Behavioural memory; when silent it only forwards injected pulses.
  initial begin
    int wcnt;
    wcnt      = 0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_silent || reset) begin
        wcnt      = 0;
        mem_valid = inject_valid;
        if (inject_valid) mem_rdata = inject_data;
      end else if (mem_valid) begin
        mem_valid = 1'b0;
        wcnt      = 0;
      end else if (mem_ready) begin
        if (wcnt >= mem_lat) begin
          mem_valid = 1'b1;
          mem_rdata = mem_addr ^ 32'h0000_0053;
        end else begin
          wcnt++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (fetch_done && access_done) overlap_cnt++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout simulation did not finish in time");
    $fatal(1, "[TB] global timeout");
  end

  task automatic wait_done(input int budget, output logic got_f, output logic got_a);
    got_f = 1'b0;
    got_a = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (fetch_done || access_done) begin
        got_f = fetch_done;
        got_a = access_done;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    fetch_req    = 1'b0;
    fetch_addr   = '0;
    access_req   = 1'b0;
    access_addr  = '0;
    access_wdata = '0;
    access_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({fetch_done, access_done, mem_ready, mem_err} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b want 0000", {fetch_done, access_done, mem_ready, mem_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin
      errors++;
      $display("[TB] FAIL reset_mem_bus got %h %h %h want 0", mem_addr, mem_wdata, mem_wstrb);
    end
    checks++;
    if ({fetch_rdata, access_rdata} !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_rdata got %h %h want 0", fetch_rdata, access_rdata);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fetch_only();
    logic gf, ga;
    exp_t e;
    mem_lat    = 2;
    fetch_addr = 32'h0000_0040;
    fetch_req  = 1'b1;
    sb.push_back('{1'b1, 32'h0000_0013});
    @(posedge clk);
    #1;
    checks++;
    if ({mem_ready, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h40, 32'h0, 4'h0}) begin
      errors++;
      $display("[TB] FAIL fetch_grant got rdy=%b addr=%h wd=%h ws=%h want 1 40 0 0",
               mem_ready, mem_addr, mem_wdata, mem_wstrb);
    end
    wait_done(20, gf, ga);
    checks++;
    if ({gf, ga} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL fetch_done_seen got f=%b a=%b want f=1 a=0", gf, ga);
    end
    if (gf && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (!e.is_fetch || fetch_rdata !== e.rdata) begin
        errors++;
        $display("[TB] FAIL fetch_rdata got %h want %h", fetch_rdata, e.rdata);
      end
    end
    fetch_req = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (fetch_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fetch_done_width got %b want 0", fetch_done);
    end
  endtask

  task automatic test_access_write();
    int   wait_cyc;
    logic stable_bad;
    exp_t e;
    wait_cyc     = 0;
    stable_bad   = 1'b0;
    mem_lat      = 3;
    access_addr  = 32'h0000_0100;
    access_wdata = 32'hDEAD_BEEF;
    access_wstrb = 4'b0011;
    access_req   = 1'b1;
    sb.push_back('{1'b0, 32'h0000_0153});
    @(posedge clk);
    #1;
    checks++;
    if ({mem_ready, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011}) begin
      errors++;
      $display("[TB] FAIL access_grant got rdy=%b addr=%h wd=%h ws=%h want 1 100 deadbeef 3",
               mem_ready, mem_addr, mem_wdata, mem_wstrb);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (access_done || fetch_done) break;
      if (mem_ready) begin
        wait_cyc++;
        if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF || mem_wstrb !== 4'b0011)
          stable_bad = 1'b1;
      end
    end
    checks++;
    if (stable_bad !== 1'b0 || wait_cyc < 3) begin
      errors++;
      $display("[TB] FAIL access_hold got unstable=%b waits=%0d want 0 and >=3", stable_bad, wait_cyc);
    end
    checks++;
    if ({access_done, fetch_done, mem_ready} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL access_done_cycle got ad=%b fd=%b rdy=%b want 1 0 0",
               access_done, fetch_done, mem_ready);
    end
    if (access_done && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (e.is_fetch || access_rdata !== e.rdata) begin
        errors++;
        $display("[TB] FAIL access_rdata got %h want %h", access_rdata, e.rdata);
      end
    end
    access_req   = 1'b0;
    access_wstrb = 4'b0000;
    @(posedge clk);
    #1;
    checks++;
    if (access_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL access_done_width got %b want 0", access_done);
    end
  endtask

  task automatic test_back_to_back();
    int   st;
    logic gf, ga;
    exp_t e;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    st    = 0;
    for (int i = 0; i < 10; i++) begin
      if (st < STARVE_LIMIT) begin
        sb.push_back('{1'b0, 32'h0000_0300 ^ 32'h53});
        st++;
      end else begin
        sb.push_back('{1'b1, 32'h0000_0200 ^ 32'h53});
        st = 0;
      end
    end
    mem_lat     = 0;
    overlap_cnt = 0;
    fetch_addr  = 32'h0000_0200;
    access_addr = 32'h0000_0300;
    fetch_req   = 1'b1;
    access_req  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_done(20, gf, ga);
      checks++;
      if (!(gf || ga) || sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL starve_done_%0d got no completion want one", i);
      end else begin
        e = sb.pop_front();
        checks++;
        if (gf !== e.is_fetch || (gf ? fetch_rdata : access_rdata) !== e.rdata) begin
          errors++;
          $display("[TB] FAIL starve_order_%0d got fetch=%b data=%h want fetch=%b data=%h",
                   i, gf, gf ? fetch_rdata : access_rdata, e.is_fetch, e.rdata);
        end
      end
    end
    fetch_req  = 1'b0;
    access_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (overlap_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL done_overlap got %0d want 0", overlap_cnt);
    end
  endtask

  task automatic test_reset_mid_access();
    int   done_seen;
    logic gf, ga;
    exp_t e;
    done_seen    = 0;
    mem_silent   = 1'b1;
    access_addr  = 32'h0000_0400;
    access_wstrb = 4'b0000;
    access_req   = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (mem_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_a_ready got %b want 1", mem_ready);
    end
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_ready, mem_addr, access_rdata, fetch_rdata} !== 97'h0) begin
      errors++;
      $display("[TB] FAIL async_reset got rdy=%b addr=%h ard=%h frd=%h want all 0",
               mem_ready, mem_addr, access_rdata, fetch_rdata);
    end
    access_req = 1'b0;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    mem_silent = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (access_done || fetch_done) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("[TB] FAIL abandoned_done got %0d pulses want 0", done_seen);
    end
    mem_lat    = 1;
    fetch_addr = 32'h0000_0080;
    fetch_req  = 1'b1;
    sb.push_back('{1'b1, 32'h0000_00D3});
    wait_done(20, gf, ga);
    checks++;
    if (!gf || sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL post_reset_fetch got f=%b a=%b want f=1", gf, ga);
    end else begin
      e = sb.pop_front();
      checks++;
      if (fetch_rdata !== e.rdata) begin
        errors++;
        $display("[TB] FAIL post_reset_rdata got %h want %h", fetch_rdata, e.rdata);
      end
    end
    fetch_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_valid_idle();
    int   bad;
    logic gf, ga;
    exp_t e;
    bad          = 0;
    mem_silent   = 1'b1;
    inject_data  = 32'hCAFE_F00D;
    inject_valid = 1'b1;
    @(posedge clk);
    #1;
    inject_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (fetch_done || access_done || mem_ready) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL idle_valid_effect got %0d bad cycles want 0", bad);
    end
    checks++;
    if (fetch_rdata !== 32'h0000_00D3 || access_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL idle_valid_rdata got %h %h want 000000d3 00000000", fetch_rdata, access_rdata);
    end
    mem_silent = 1'b0;
    mem_lat    = 0;
    fetch_addr = 32'h0000_0044;
    fetch_req  = 1'b1;
    sb.push_back('{1'b1, 32'h0000_0017});
    @(posedge clk);
    #1;
    checks++;
    if (mem_ready !== 1'b1 || mem_addr !== 32'h44) begin
      errors++;
      $display("[TB] FAIL idle_still_idle got rdy=%b addr=%h want 1 44", mem_ready, mem_addr);
    end
    wait_done(20, gf, ga);
    if (gf && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (fetch_rdata !== e.rdata) begin
        errors++;
        $display("[TB] FAIL idle_follow_rdata got %h want %h", fetch_rdata, e.rdata);
      end
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_follow_done got f=%b a=%b want f=1", gf, ga);
    end
    fetch_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
    logic gf, ga;
    exp_t e;
    mem_silent = 1'b1;
    fetch_addr = 32'h0000_0048;
    fetch_req  = 1'b1;
    sb.push_back('{1'b1, 32'hFFFF_FFFF});
    wait_done(TIMEOUT_CYCLES + 20, gf, ga);
    checks++;
    if (!gf || sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL timeout_done got f=%b a=%b want f=1", gf, ga);
    end else begin
      e = sb.pop_front();
      checks++;
      if (fetch_rdata !== e.rdata) begin
        errors++;
        $display("[TB] FAIL timeout_rdata got %h want %h", fetch_rdata, e.rdata);
      end
    end
    fetch_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (mem_err !== 1'b1 || mem_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_err got err=%b rdy=%b want 1 0", mem_err, mem_ready);
    end
`else
    int done_seen;
    done_seen  = 0;
    mem_silent = 1'b1;
    fetch_addr = 32'h0000_0048;
    fetch_req  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (fetch_done || access_done) done_seen++;
    end
    checks++;
    if (mem_ready !== 1'b1 || mem_err !== 1'b0 || done_seen !== 0) begin
      errors++;
      $display("[TB] FAIL no_watchdog got rdy=%b err=%b dones=%0d want 1 0 0",
               mem_ready, mem_err, done_seen);
    end
    fetch_req = 1'b0;
`endif
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    mem_silent = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_access_write();
    test_back_to_back();
    test_reset_mid_access();
    test_valid_idle();
    test_timeout();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_left got %0d entries want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared memory port between the instruction fetcher (port F) and the load/store accessor (port A).
- Sits between the pipeline stages and the top-level mem_* bus.
- Owns mem_ready/mem_addr/mem_wdata/mem_wstrb, runs one transaction at a time, and returns read data plus a done pulse to the owning requester.
- Accessor has priority, since it holds the older instruction; a starvation counter guarantees fetch progress.

Parameters:
- STARVE_LIMIT, 4: max consecutive A grants while F is pending before F is forced; range 1..15.
- TIMEOUT_CYCLES, 255: watchdog limit in cycles; used only with MEM_TIMEOUT_EN; 8-bit counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- fetch_req  in  1  F requests a read; held high until fetch_done.
- fetch_addr  in  32  F word address; stable while fetch_req high.
- fetch_done  out  1  one-cycle pulse; fetch_rdata valid this cycle.
- fetch_rdata  out  32  registered read data for F.
- access_req  in  1  A requests a transaction; held high until access_done.
- access_addr  in  32  A address; stable while access_req high.
- access_wdata  in  32  A write data.
- access_wstrb  in  4  A byte strobes; 0 = read.
- access_done  out  1  one-cycle pulse; access_rdata valid this cycle.
- access_rdata  out  32  registered read data for A.
- mem_ready  out  1  request to memory, held until mem_valid.
- mem_addr  out  32  latched transaction address.
- mem_wdata  out  32  latched write data.
- mem_wstrb  out  4  latched strobes; always 0 for F.
- mem_valid  in  1  memory response/acknowledge.
- mem_rdata  in  32  memory read data, valid with mem_valid.
- mem_err  out  1  sticky timeout flag; tied 0 without MEM_TIMEOUT_EN.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; starve_cnt=0; watchdog=0. Any in-flight transaction is abandoned with no done pulse.
- States:
  - IDLE: evaluate requests.
  - BUSY_F: F transaction outstanding.
  - BUSY_A: A transaction outstanding.
- IDLE arbitration at each clk edge:
  - Requests are masked for a port whose done is high in the current cycle (requester is dropping req).
  - Both requesting and starve_cnt < STARVE_LIMIT: grant A, starve_cnt+1.
  - Both requesting and starve_cnt == STARVE_LIMIT: grant F, starve_cnt=0.
  - Only A: grant A; starve_cnt unchanged.
  - Only F: grant F, starve_cnt=0.
  - Neither: stay IDLE.
- On grant, latch the requester's addr/wdata/wstrb into mem_addr/mem_wdata/mem_wstrb; mem_ready=1 from the next cycle. For F, mem_wdata=0 and mem_wstrb=0.
- BUSY_x:
  - mem_* outputs held constant until mem_valid sampled high.
  - On that edge: mem_ready->0; state->IDLE; x_rdata<=mem_rdata (A writes: rdata still captured, but don't-care); x_done=1 for exactly one cycle.
- Latency:
  - req high at edge n (IDLE) -> mem_ready high cycle n+1.
  - mem_valid at edge m -> done in cycle m+1.
  - Next grant earliest at edge m+2, giving 3-cycle minimum turnaround per transaction with zero-wait memory.
- mem_valid while IDLE: ignored, no done pulse.
- req deasserted mid-transaction: protocol violation; transaction completes and done still pulses.
- fetch_done and access_done are never high in the same cycle.
- rdata holds its last value between transactions.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - Watchdog counts cycles in BUSY_x and clears on grant.
  - When it reaches TIMEOUT_CYCLES without mem_valid: mem_ready->0; state->IDLE; x_done pulses with x_rdata=32'hFFFF_FFFF; mem_err set sticky until reset.
  - mem_valid arriving later while IDLE is ignored.
- Undefined: no watchdog; BUSY waits indefinitely; mem_err tied 0.

Test Plan:
- F only, fetch_addr=0x0000_0040, memory responds 2 cycles after mem_ready with 0x0000_0013 -> mem_addr=0x40, mem_wstrb=0, fetch_done one cycle, fetch_rdata=0x13.
- A write, addr=0x100, wdata=0xDEAD_BEEF, wstrb=4'b0011 -> mem_wdata/mem_wstrb match and stay stable through 3 wait cycles; single access_done pulse; mem_ready low the cycle after mem_valid.
- F and A both held high continuously, STARVE_LIMIT=4 -> grant order A,A,A,A,F,A,A,A,A,F; no done overlap.
- Reset asserted mid BUSY_A -> all outputs 0 immediately (async); no access_done; a fresh F request after reset is served normally.
- mem_valid pulsed in IDLE -> no done, no state change.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory silent -> after 8 BUSY cycles fetch_done pulses with rdata 0xFFFF_FFFF and mem_err=1 stays high; without the macro, mem_ready stays high indefinitely.
